// File: rtl/gate_emu_pkg.sv
// Shared definitions for the gate emulator: gate codes (also used by the gate tester),
// FSM state encoding and output-pin masks.
package gate_emu_pkg;

  typedef enum logic [2:0] {
    GateNone = 3'd0,
    GateNot  = 3'd1,
    GateAnd  = 3'd2,
    GateOr   = 3'd3,
    GateXor  = 3'd4
  } gate_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StArm  = 2'd1,
    StRun  = 2'd2
  } state_e;

  localparam int unsigned NumPins = 12;
  localparam logic [11:0] NotMask = 12'hAAA;
  localparam logic [11:0] TwoInMask = 12'h924;

  function automatic logic gate_valid(logic [2:0] code);
    return (code >= 3'd1) && (code <= 3'd4);
  endfunction

  function automatic logic [11:0] out_mask(gate_e g);
    logic [11:0] m;
    case (g)
      GateNot:                  m = NotMask;
      GateAnd, GateOr, GateXor: m = TwoInMask;
      default:                  m = '0;
    endcase
    return m;
  endfunction

  function automatic logic gate_eval2(gate_e g, logic a, logic b);
    logic r;
    case (g)
      GateAnd: r = a & b;
      GateOr:  r = a | b;
      GateXor: r = a ^ b;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_emu_sync.sv
// Two-flop synchronizer for asynchronous input levels, async active-low reset.
module gate_emu_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/gate_emulator.sv
// Emulates NOT/AND/OR/XOR gates on a 12-pin header with an IDLE/ARM/RUN handshake.
// Optional GATE_EMU_FAULT_INJECT_EN adds per-slot output inversion via fault_mask.
module gate_emulator
  import gate_emu_pkg::*;
#(
  parameter int unsigned DELAY  = 2,
  parameter int unsigned SETTLE = 4
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [2:0]  gate_type,
  input  logic [11:0] pins_in,
  input  logic [5:0]  fault_mask,
  output logic [11:0] pins_out,
  output logic [11:0] pins_dir,
  output logic [1:0]  state,
  output logic [15:0] eval_cnt
);

  localparam int unsigned ArmW = $clog2(SETTLE + 1);

  if (DELAY < 1 || DELAY > 8 || SETTLE < DELAY + 2) begin : g_param_check
    $error("gate_emulator: DELAY must be 1..8 and SETTLE >= DELAY+2");
  end

  logic [11:0] pins_sync;
  logic [11:0] gate_out;
  logic [11:0] pipe_q [DELAY];

  state_e          state_q, state_d;
  gate_e           type_q, type_d;
  logic [ArmW-1:0] arm_cnt_q, arm_cnt_d;
  logic [15:0]     eval_q, eval_d;
  logic [11:0]     dir_q, dir_d;
  logic [11:0]     prev_out_q;
  logic            abort;

`ifndef GATE_EMU_FAULT_INJECT_EN
  logic unused_fault_mask;
  assign unused_fault_mask = ^fault_mask;
`endif

  gate_emu_sync #(
    .WIDTH(NumPins)
  ) u_sync (
    .clk  (CLOCK_50),
    .rst_n(reset_n),
    .d    (pins_in),
    .q    (pins_sync)
  );

  always_comb begin
    gate_out = '0;
    unique case (type_q)
      GateNot: begin
        for (int k = 0; k < 6; k++) begin
`ifdef GATE_EMU_FAULT_INJECT_EN
          gate_out[2*k+1] = ~pins_sync[2*k] ^ fault_mask[k];
`else
          gate_out[2*k+1] = ~pins_sync[2*k];
`endif
        end
      end
      GateAnd, GateOr, GateXor: begin
        for (int k = 0; k < 4; k++) begin
`ifdef GATE_EMU_FAULT_INJECT_EN
          gate_out[3*k+2] = gate_eval2(type_q, pins_sync[3*k], pins_sync[3*k+1]) ^ fault_mask[k];
`else
          gate_out[3*k+2] = gate_eval2(type_q, pins_sync[3*k], pins_sync[3*k+1]);
`endif
        end
      end
      default: ;
    endcase
  end

  // Pipeline runs in every state so it is already primed when ARM hands over to RUN.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DELAY); i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= gate_out;
      for (int i = 1; i < int'(DELAY); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_comb begin
    pins_out = '0;
    if (state_q == StRun) pins_out = pipe_q[DELAY-1] & out_mask(type_q);
  end

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    arm_cnt_d = arm_cnt_q;
    eval_d    = eval_q;
    abort     = !enable || (gate_type != type_q);
    unique case (state_q)
      StIdle: begin
        if (enable && gate_valid(gate_type)) begin
          type_d    = gate_e'(gate_type);
          arm_cnt_d = '0;
          eval_d    = '0;
          state_d   = StArm;
        end
      end
      StArm: begin
        if (abort) begin
          state_d = StIdle;
        end else if (arm_cnt_q == ArmW'(SETTLE - 1)) begin
          state_d = StRun;
        end else begin
          arm_cnt_d = arm_cnt_q + 1'b1;
        end
      end
      StRun: begin
        if ((|((pins_out ^ prev_out_q) & out_mask(type_q))) && (eval_q != 16'hFFFF)) begin
          eval_d = eval_q + 16'd1;
        end
        if (abort) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    dir_d = (state_d == StRun) ? out_mask(type_d) : '0;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      type_q     <= GateNone;
      arm_cnt_q  <= '0;
      eval_q     <= '0;
      dir_q      <= '0;
      prev_out_q <= '0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      arm_cnt_q  <= arm_cnt_d;
      eval_q     <= eval_d;
      dir_q      <= dir_d;
      prev_out_q <= pins_out;
    end
  end

  assign pins_dir = dir_q;
  assign state    = state_q;
  assign eval_cnt = eval_q;

endmodule

// File: tb/tb_gate_emulator.sv
// Self-checking bench for gate_emulator against a cycle-level behavioural model.
// Honours GATE_EMU_FAULT_INJECT_EN when deciding expected fault inversion.
module tb_gate_emulator;

  localparam int DELAY  = 2;
  localparam int SETTLE = 4;

  logic        CLOCK_50;
  logic        reset_n;
  logic        enable;
  logic [2:0]  gate_type;
  logic [11:0] pins_in;
  logic [5:0]  fault_mask;
  logic [11:0] pins_out;
  logic [11:0] pins_dir;
  logic [1:0]  state;
  logic [15:0] eval_cnt;

  int total;
  int bad;

  gate_emulator #(
    .DELAY (DELAY),
    .SETTLE(SETTLE)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .enable    (enable),
    .gate_type (gate_type),
    .pins_in   (pins_in),
    .fault_mask(fault_mask),
    .pins_out  (pins_out),
    .pins_dir  (pins_dir),
    .state     (state),
    .eval_cnt  (eval_cnt)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  // Behavioural model: state as 0/1/2, raw input history of DELAY+2 edges.
  int          m_state;
  logic [2:0]  m_type;
  int          m_arm;
  logic [15:0] m_eval;
  logic [11:0] m_prev;
  logic [11:0] hist[$];

  function automatic logic [11:0] mask_of(logic [2:0] t);
    if (t == 3'd1) return 12'hAAA;
    if (t >= 3'd2 && t <= 3'd4) return 12'h924;
    return 12'h000;
  endfunction

  function automatic logic [11:0] gate_fn(logic [2:0] t, logic [11:0] p, logic [5:0] fm);
    logic [11:0] o;
    logic a, b, v;
    o = '0;
    if (t == 3'd1) begin
      for (int k = 0; k < 6; k++) begin
        v = !p[2*k];
`ifdef GATE_EMU_FAULT_INJECT_EN
        v = v ^ fm[k];
`endif
        o[2*k+1] = v;
      end
    end else if (t >= 3'd2 && t <= 3'd4) begin
      for (int k = 0; k < 4; k++) begin
        a = p[3*k];
        b = p[3*k+1];
        v = (t == 3'd2) ? (a & b) : (t == 3'd3) ? (a | b) : (a ^ b);
`ifdef GATE_EMU_FAULT_INJECT_EN
        v = v ^ fm[k];
`endif
        o[3*k+2] = v;
      end
    end
    return o;
  endfunction

  function automatic logic [11:0] exp_out();
    if (m_state != 2) return 12'h000;
    return gate_fn(m_type, hist[0], fault_mask) & mask_of(m_type);
  endfunction

  function automatic logic [11:0] exp_dir();
    return (m_state == 2) ? mask_of(m_type) : 12'h000;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_type  = 3'd0;
    m_arm   = 0;
    m_eval  = 16'd0;
    m_prev  = 12'h000;
    hist.delete();
    repeat (DELAY + 2) hist.push_back(12'h000);
  endtask

  // One clock: advance model with the inputs held across the edge, return at the negedge.
  task automatic tick();
    logic [11:0] cur;
    logic        en;
    logic [2:0]  gt;
    logic [11:0] pin;
    cur = exp_out();
    en  = enable;
    gt  = gate_type;
    pin = pins_in;
    @(posedge CLOCK_50);
    case (m_state)
      0: begin
        if (en && gt >= 3'd1 && gt <= 3'd4) begin
          m_type  = gt;
          m_arm   = 0;
          m_eval  = 16'd0;
          m_state = 1;
        end
      end
      1: begin
        if (!en || gt != m_type) m_state = 0;
        else begin
          m_arm++;
          if (m_arm == SETTLE) m_state = 2;
        end
      end
      default: begin
        if (((cur ^ m_prev) & mask_of(m_type)) != 12'h000 && m_eval != 16'hFFFF) m_eval++;
        if (!en || gt != m_type) m_state = 0;
      end
    endcase
    m_prev = cur;
    hist.push_back(pin);
    void'(hist.pop_front());
    @(negedge CLOCK_50);
  endtask

  task automatic run_random(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      pins_in = 12'($urandom);
      tick();
      total++;
      if (pins_out !== exp_out() || eval_cnt !== m_eval) begin
        bad++;
        $display("FAIL %s_rand[%0d] got out=%h eval=%0d exp out=%h eval=%0d",
                 name, i, pins_out, eval_cnt, exp_out(), m_eval);
      end
    end
  endtask

  task automatic wait_run(input string name);
    int n;
    n = 0;
    while (m_state != 2 && n < 12) begin
      tick();
      n++;
    end
    total++;
    if (state !== 2'd2 || m_state != 2) begin
      bad++;
      $display("FAIL %s_reach_run got state=%0d exp state=2", name, state);
    end
  endtask

  task automatic test_reset();
    reset_n    = 1'b1;
    enable     = 1'b0;
    gate_type  = 3'd0;
    pins_in    = 12'h000;
    fault_mask = 6'b000001;
    #1 reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge CLOCK_50);
    total++;
    if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    total++;
    if (pins_dir !== 12'h000 || pins_out !== 12'h000) begin
      bad++;
      $display("FAIL reset_pins got dir=%h out=%h exp 000/000", pins_dir, pins_out);
    end
    total++;
    if (eval_cnt !== 16'd0) begin bad++; $display("FAIL reset_eval got=%0d exp=0", eval_cnt); end
    reset_n = 1'b1;
  endtask

  task automatic test_not();
    logic [11:0] exp_a, exp_b;
`ifdef GATE_EMU_FAULT_INJECT_EN
    exp_a = 12'hAAA;
    exp_b = 12'hAA8;
`else
    exp_a = 12'hAA8;
    exp_b = 12'hAAA;
`endif
    enable = 1'b1;
    gate_type = 3'd1;
    pins_in = 12'h000;
    tick();
    total++;
    if (state !== 2'd1) begin bad++; $display("FAIL not_arm_entry got=%0d exp=1", state); end
    repeat (3) tick();
    total++;
    if (state !== 2'd1 || pins_dir !== 12'h000) begin
      bad++;
      $display("FAIL not_arm_hold got state=%0d dir=%h exp 1/000", state, pins_dir);
    end
    tick();
    total++;
    if (state !== 2'd2 || pins_dir !== 12'hAAA) begin
      bad++;
      $display("FAIL not_run_entry got state=%0d dir=%h exp 2/aaa", state, pins_dir);
    end
    pins_in = 12'h001;
    repeat (4) tick();
    total++;
    if (pins_out !== exp_a) begin
      bad++;
      $display("FAIL not_pin0_high got=%h exp=%h", pins_out, exp_a);
    end
    pins_in = 12'h000;
    repeat (3) tick();
    total++;
    if (pins_out !== exp_a) begin
      bad++;
      $display("FAIL not_latency_early got=%h exp=%h", pins_out, exp_a);
    end
    tick();
    total++;
    if (pins_out !== exp_b) begin
      bad++;
      $display("FAIL not_pin0_low got=%h exp=%h", pins_out, exp_b);
    end
    run_random(40, "not");
  endtask

  task automatic test_and();
    logic [3:0] and_tab;
    and_tab = 4'b1000;
    gate_type = 3'd2;
    tick();
    total++;
    if (state !== 2'd0 || pins_dir !== 12'h000) begin
      bad++;
      $display("FAIL and_abort got state=%0d dir=%h exp 0/000", state, pins_dir);
    end
    wait_run("and");
    total++;
    if (pins_dir !== 12'h924) begin bad++; $display("FAIL and_dir got=%h exp=924", pins_dir); end
    for (int i = 0; i < 4; i++) begin
      pins_in = 12'h000;
      pins_in[6] = i[1];
      pins_in[7] = i[0];
      repeat (4) tick();
      total++;
      if (pins_out[8] !== and_tab[i]) begin
        bad++;
        $display("FAIL and_combo[%0d] got=%b exp=%b", i, pins_out[8], and_tab[i]);
      end
    end
    run_random(30, "and");
  endtask

  task automatic test_switch();
    gate_type = 3'd4;
    tick();
    wait_run("xor");
    run_random(20, "xor");
    gate_type = 3'd3;
    tick();
    total++;
    if (state !== 2'd0 || pins_dir !== 12'h000) begin
      bad++;
      $display("FAIL switch_idle got state=%0d dir=%h exp 0/000", state, pins_dir);
    end
    total++;
    if (eval_cnt !== m_eval) begin
      bad++;
      $display("FAIL switch_eval_hold got=%0d exp=%0d", eval_cnt, m_eval);
    end
    tick();
    total++;
    if (state !== 2'd1 || eval_cnt !== 16'd0) begin
      bad++;
      $display("FAIL switch_arm got state=%0d eval=%0d exp 1/0", state, eval_cnt);
    end
    wait_run("or");
    total++;
    if (pins_dir !== 12'h924 || eval_cnt !== 16'd0) begin
      bad++;
      $display("FAIL or_run_entry got dir=%h eval=%0d exp 924/0", pins_dir, eval_cnt);
    end
    run_random(20, "or");
  endtask

  task automatic test_invalid();
    logic [2:0] codes [4];
    codes = '{3'd6, 3'd0, 3'd5, 3'd7};
    for (int c = 0; c < 4; c++) begin
      gate_type = codes[c];
      for (int i = 0; i < ((c == 0) ? 20 : 4); i++) begin
        pins_in = 12'($urandom);
        tick();
        total++;
        if (state !== 2'd0 || pins_dir !== 12'h000 || pins_out !== 12'h000) begin
          bad++;
          $display("FAIL invalid_%0d[%0d] got state=%0d dir=%h out=%h exp 0/000/000",
                   codes[c], i, state, pins_dir, pins_out);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    gate_type = 3'd1;
    tick();
    wait_run("rst");
    run_random(8, "rst_pre");
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (pins_dir !== 12'h000 || pins_out !== 12'h000) begin
      bad++;
      $display("FAIL reset_async got dir=%h out=%h exp 000/000", pins_dir, pins_out);
    end
    repeat (2) @(negedge CLOCK_50);
    model_reset();
    reset_n = 1'b1;
    total++;
    if (state !== 2'd0 || eval_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_release got state=%0d eval=%0d exp 0/0", state, eval_cnt);
    end
    wait_run("rst_post");
    run_random(20, "rst_post");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(15) == 0) gate_type = 3'($urandom_range(7));
      enable  = ($urandom_range(31) != 0);
      pins_in = 12'($urandom);
      tick();
      total++;
      if (state !== 2'(m_state) || pins_dir !== exp_dir()) begin
        bad++;
        $display("FAIL b2b_ctrl[%0d] got state=%0d dir=%h exp state=%0d dir=%h",
                 i, state, pins_dir, m_state, exp_dir());
      end
      total++;
      if (pins_out !== exp_out() || eval_cnt !== m_eval) begin
        bad++;
        $display("FAIL b2b_data[%0d] got out=%h eval=%0d exp out=%h eval=%0d",
                 i, pins_out, eval_cnt, exp_out(), m_eval);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_not();
    test_and();
    test_switch();
    test_invalid();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_emulator.md
GATE_EMULATOR -- requirements
Module: gate_emulator

Interface
REQ-001 The block SHALL have parameter DELAY, default 2, which sets the number of output pipeline stages (legal range 1..8).
REQ-002 The block SHALL have parameter SETTLE, default 4, which sets the number of cycles spent in ARM; it SHALL be at least DELAY+2 (checked at elaboration).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with the ports listed below in this order.
- CLOCK_50  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  emulation enable
- gate_type  in  3  requested gate: 0 NONE, 1 NOT, 2 AND, 3 OR, 4 XOR; 5..7 invalid
- pins_in  in  12  sampled pin levels, async to CLOCK_50
- fault_mask  in  6  per-slot output inversion (used only with FAULT_INJECT_EN)
- pins_out  out  12  pin drive values
- pins_dir  out  12  pin direction, 1 = drive, 0 = high-Z
- state  out  2  0 IDLE, 1 ARM, 2 RUN
- eval_cnt  out  16  count of output transitions in RUN

Function
REQ-004 pins_in SHALL pass through a 2-flop synchronizer before any use.
REQ-005 NOT mapping SHALL use 6 slots: slot k takes pin 2k as input and drives pin 2k+1 with the inverse of pin 2k.
REQ-006 AND, OR and XOR mapping SHALL use 4 slots: slot k takes pins 3k and 3k+1 as inputs and drives pin 3k+2 with the gate function of those two inputs.
REQ-007 Gate outputs SHALL be computed from the synchronized inputs and the latched type, then delayed by a DELAY-stage pipeline that runs every cycle.
REQ-008 A pins_in change stable from cycle n SHALL appear on pins_out at cycle n+2+DELAY, while the block is in RUN.
REQ-009 In IDLE, if enable=1 and gate_type is 1..4, the block SHALL latch gate_type, clear the ARM counter and go to ARM.
- Otherwise it SHALL stay in IDLE.
REQ-010 ARM SHALL last exactly SETTLE cycles, with pins_dir held at 0, and then go to RUN.
REQ-011 On entering RUN, pins_dir SHALL equal the output-pin mask of the latched type: NOT 0xAAA; 2-input types 0x924.
REQ-012 In RUN, pins_out bits on output pins SHALL equal the pipeline tail, and all other bits SHALL be 0.
REQ-013 From ARM or RUN, enable=0 or gate_type not equal to the latched type SHALL cause a transition to IDLE on the next edge.
- pins_dir SHALL become 0 on that same edge.
- Abort has priority over the ARM to RUN transition.
REQ-014 In IDLE, pins_dir and pins_out SHALL be 0.
REQ-015 In RUN, eval_cnt SHALL increment by 1 on every cycle in which any output-pin bit of pins_out changes.
- It SHALL saturate at 0xFFFF.
- It SHALL clear on entry to ARM.
- It SHALL hold its value in IDLE.
REQ-016 An invalid gate_type (0 or 5..7) SHALL never leave IDLE.

Reset
REQ-017 While reset_n=0, pins_dir SHALL be 0 immediately and asynchronously, so all pins are high-Z.
REQ-018 Reset SHALL set: pins_out=0, state=IDLE, eval_cnt=0, synchronizer and pipeline flops=0, latched type=NONE, ARM counter=0.
REQ-019 Reset asserted during RUN SHALL release the pins within the same cycle; after release the block SHALL resume from IDLE.

Configuration
REQ-020 With macro GATE_EMU_FAULT_INJECT_EN defined, fault_mask[k]=1 SHALL invert the output of slot k at the pipeline input.
- Bits 4..5 SHALL be ignored in 2-input modes.
REQ-021 Without GATE_EMU_FAULT_INJECT_EN, fault_mask SHALL be ignored and no inversion logic SHALL exist.

Structure
REQ-022 Package gate_emu_pkg SHALL hold: the gate type codes (shared with the gate tester), the state encoding, and the output masks 0xAAA and 0x924.
REQ-023 The synchronizer SHALL be sub-module gate_emu_sync (width parameter, 2 flops, async active-low reset).

Verification
REQ-024 The bench SHALL cover these directed scenarios (DELAY=2, SETTLE=4):
- NOT, enable=1: RUN after 1+4 cycles; pins_dir=0xAAA. Drive pin0=0 → pin1=1 four cycles later; pin0=1 → pin1=0.
- AND: drive all four {a,b} combinations on slot 2 (pins 6,7) → pin 8 = 0,0,0,1. pins_dir=0x924.
- XOR in RUN: change gate_type to OR → next edge state=IDLE, pins_dir=0. Then ARM→RUN with the OR mask and eval_cnt=0.
- gate_type=6 with enable=1 for 20 cycles → state stays IDLE, pins_dir=0.
- reset_n low mid-RUN → pins_dir=0 with no clock edge. After release → IDLE, eval_cnt=0.
- GATE_EMU_FAULT_INJECT_EN, NOT, fault_mask=6'b000001 → pin1 equals pin0 and other slots invert. Without the macro → pin1=~pin0.
